// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the adder-sharing arbiter.
package adder_arb_pkg;

   // Transaction sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SREQ = 2'd1,
      SREL = 2'd2,
      MACK = 2'd3
   } arb_state_e;

   // Default operand/result width of the shared adder
   localparam int ARB_W = 25;

   // Width of the optional adder-ack timeout counter
   localparam int ARB_TMO_W = 8;

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting
// at ptr, wrapping from NREQ-1 back to 0, and returns the first hit.
module rr_pick
   import adder_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int GW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   ptr,
   output logic            valid,
   output logic [GW-1:0]   idx
);

   // First requester at or after ptr (in wrap order) wins
   always_comb begin
      int            c;
      logic [GW-1:0] cand;
      valid = 1'b0;
      idx   = '0;
      c     = 0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         c = int'(ptr) + k;
         if (c >= NREQ) c = c - NREQ;
         cand = GW'(c);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ four-phase requesters.
// The winner's operands are latched and presented to the adder with a
// four-phase req/ack; the captured result is returned with a four-phase ack.
// Optional feature macro: ARB_TIMEOUT_EN -- abandons an adder transaction
// that is not acknowledged within TMO_CYC cycles and flags it on M_ERR.
module adder_share_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int W       = ARB_W,
   parameter int TMO_CYC = 64
) (
   input  logic                                 CLK,
   input  logic                                 RSTn,
   input  logic [NREQ-1:0]                      M_req,
   input  logic [NREQ*W-1:0]                    M_A,
   input  logic [NREQ*W-1:0]                    M_B,
   output logic [NREQ-1:0]                      M_ack,
   output logic [W-1:0]                         M_Z,
   output logic                                 M_COUT,
   output logic                                 M_ERR,
   output logic                                 S_req,
   output logic [W-1:0]                         S_A,
   output logic [W-1:0]                         S_B,
   input  logic                                 S_ack,
   input  logic [W-1:0]                         S_Z,
   input  logic                                 S_COUT,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] GNT
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e      state_q, state_d;
   logic [GW-1:0]   ptr_q,   ptr_d;
   logic [GW-1:0]   gnt_q,   gnt_d;
   logic [W-1:0]    sa_q,    sa_d;
   logic [W-1:0]    sb_q,    sb_d;
   logic            sreq_q,  sreq_d;
   logic [NREQ-1:0] mack_q,  mack_d;
   logic [W-1:0]    mz_q,    mz_d;
   logic            mcout_q, mcout_d;

   logic            pick_vld;
   logic [GW-1:0]   pick_idx;

`ifdef ARB_TIMEOUT_EN
   localparam logic [ARB_TMO_W-1:0] TMO_LAST = ARB_TMO_W'(TMO_CYC - 1);
   logic                 merr_q, merr_d;
   logic [ARB_TMO_W-1:0] cnt_q,  cnt_d;
`endif

   rr_pick #(
      .NREQ (NREQ),
      .GW   (GW)
   ) u_pick (
      .req   (M_req),
      .ptr   (ptr_q),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // Next-state and register-update logic of the transaction sequencer
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sreq_d  = sreq_q;
      mack_d  = mack_q;
      mz_d    = mz_q;
      mcout_d = mcout_q;
`ifdef ARB_TIMEOUT_EN
      merr_d  = merr_q;
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            // A still-high ack from a previous (or abandoned) transaction
            // must fall before a new request is launched.
            if (pick_vld && !S_ack) begin
               gnt_d   = pick_idx;
               sa_d    = M_A[int'(pick_idx)*W +: W];
               sb_d    = M_B[int'(pick_idx)*W +: W];
               sreq_d  = 1'b1;
               state_d = SREQ;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
               merr_d  = 1'b0;
`endif
            end
         end
         SREQ: begin
            if (S_ack) begin
               mz_d    = S_Z;
               mcout_d = S_COUT;
               sreq_d  = 1'b0;
               state_d = SREL;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               mz_d    = '0;
               mcout_d = 1'b0;
               merr_d  = 1'b1;
               sreq_d  = 1'b0;
               state_d = SREL;
            end else begin
               cnt_d   = cnt_q + ARB_TMO_W'(1);
            end
`endif
         end
         SREL: begin
            if (!S_ack) begin
               mack_d[gnt_q] = 1'b1;
               state_d       = MACK;
            end
         end
         MACK: begin
            // A requester that already dropped its request sees a one-cycle ack
            if (!M_req[gnt_q]) begin
               mack_d  = '0;
               ptr_d   = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + GW'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; everything clears on reset
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         sa_q    <= '0;
         sb_q    <= '0;
         sreq_q  <= 1'b0;
         mack_q  <= '0;
         mz_q    <= '0;
         mcout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         merr_q  <= 1'b0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sreq_q  <= sreq_d;
         mack_q  <= mack_d;
         mz_q    <= mz_d;
         mcout_q <= mcout_d;
`ifdef ARB_TIMEOUT_EN
         merr_q  <= merr_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign M_ack  = mack_q;
   assign M_Z    = mz_q;
   assign M_COUT = mcout_q;
   assign S_req  = sreq_q;
   assign S_A    = sa_q;
   assign S_B    = sb_q;
   assign GNT    = gnt_q;
`ifdef ARB_TIMEOUT_EN
   assign M_ERR  = merr_q;
`else
   assign M_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with four requesters.
// Behavioural adder and requester responders run #1 after each rising edge.
module tb_adder_share_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 25;

   logic              CLK  = 1'b0;
   logic              RSTn = 1'b0;
   logic [NREQ-1:0]   M_req = '0;
   logic [NREQ*W-1:0] M_A = '0;
   logic [NREQ*W-1:0] M_B = '0;
   logic [NREQ-1:0]   M_ack;
   logic [W-1:0]      M_Z;
   logic              M_COUT;
   logic              M_ERR;
   logic              S_req;
   logic [W-1:0]      S_A;
   logic [W-1:0]      S_B;
   logic              S_ack  = 1'b0;
   logic [W-1:0]      S_Z    = '0;
   logic              S_COUT = 1'b0;
   logic [1:0]        GNT;

   adder_share_arbiter #(
      .NREQ    (NREQ),
      .W       (W),
      .TMO_CYC (64)
   ) dut (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .M_req  (M_req),
      .M_A    (M_A),
      .M_B    (M_B),
      .M_ack  (M_ack),
      .M_Z    (M_Z),
      .M_COUT (M_COUT),
      .M_ERR  (M_ERR),
      .S_req  (S_req),
      .S_A    (S_A),
      .S_B    (S_B),
      .S_ack  (S_ack),
      .S_Z    (S_Z),
      .S_COUT (S_COUT),
      .GNT    (GNT)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // adder_mode: 0 = acks one cycle after S_req, 1 = S_ack forced to stale_val, 2 = never acks
   int   adder_mode = 0;
   logic stale_val  = 1'b0;

   int         quota  [NREQ] = '{default: 0};
   int         served [NREQ] = '{default: 0};
   int         ord    [64]   = '{default: 0};
   int         ord_n  = 0;
   logic [1:0] last_gnt  = '0;
   logic [W-1:0] last_z  = '0;
   logic       last_cout = 1'b0;
   logic       last_err  = 1'b0;

   // Behavioural four-phase adder
   always @(posedge CLK) begin
      #1;
      if (adder_mode == 0) begin
         if (S_req && !S_ack) begin
            {S_COUT, S_Z} = {1'b0, S_A} + {1'b0, S_B};
            S_ack = 1'b1;
         end else if (!S_req && S_ack) begin
            S_ack = 1'b0;
         end
      end else if (adder_mode == 1) begin
         S_ack = stale_val;
      end else begin
         S_ack = 1'b0;
      end
   end

   // Four-phase requesters: raise while quota outstanding, drop on ack and log it
   always @(posedge CLK) begin
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (M_req[i] && M_ack[i]) begin
            M_req[i]  = 1'b0;
            served[i] = served[i] + 1;
            last_gnt  = GNT;
            last_z    = M_Z;
            last_cout = M_COUT;
            last_err  = M_ERR;
            if (ord_n < 64) begin
               ord[ord_n] = i;
               ord_n      = ord_n + 1;
            end
         end else if (!M_req[i] && !M_ack[i] && served[i] < quota[i]) begin
            M_req[i] = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_served(input int i, input int target, input int budget);
      int n;
      n = 0;
      while (served[i] < target && n < budget) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (served[i] < target) begin
         errors++;
         $display("FAIL served%0d: got %0d expected %0d (timeout)", i, served[i], target);
      end
   endtask

   task automatic wait_sreq(input string nm, input int budget);
      int n;
      n = 0;
      while (!S_req && n < budget) begin
         @(negedge CLK);
         n++;
      end
      chk(nm, 64'(S_req), 64'(1));
   endtask

   task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      M_A[i*W +: W] = a;
      M_B[i*W +: W] = b;
      quota[i]      = served[i] + 1;
   endtask

   typedef struct {
      int           idx;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] z;
      logic         c;
   } vec_t;

   vec_t tv [6];

   initial begin
      int tgt;
      int o0;
      int cnt;
      logic seen;

      tv[0] = '{0, 25'h0000001, 25'h1FFFFFF, 25'h0000000, 1'b1};
      tv[1] = '{1, 25'h0123456, 25'h0654321, 25'h0777777, 1'b0};
      tv[2] = '{2, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFE, 1'b1};
      tv[3] = '{3, 25'h0000000, 25'h0000000, 25'h0000000, 1'b0};
      tv[4] = '{0, 25'h1000000, 25'h1000000, 25'h0000000, 1'b1};
      tv[5] = '{3, 25'h0ABCDEF, 25'h1000000, 25'h1ABCDEF, 1'b0};

      // Reset state
      #1;
      chk("rst_S_req",  64'(S_req),  64'(0));
      chk("rst_M_ack",  64'(M_ack),  64'(0));
      chk("rst_M_Z",    64'(M_Z),    64'(0));
      chk("rst_M_COUT", 64'(M_COUT), 64'(0));
      chk("rst_M_ERR",  64'(M_ERR),  64'(0));
      chk("rst_GNT",    64'(GNT),    64'(0));
      chk("rst_S_A",    64'(S_A),    64'(0));
      repeat (3) @(negedge CLK);
      RSTn = 1'b1;
      @(negedge CLK);

      // Single transactions from the vector table
      for (int v = 0; v < 6; v++) begin
         issue(tv[v].idx, tv[v].a, tv[v].b);
         tgt = quota[tv[v].idx];
         wait_served(tv[v].idx, tgt, 50);
         @(negedge CLK);
         chk($sformatf("v%0d_Z", v),    64'(last_z),    64'(tv[v].z));
         chk($sformatf("v%0d_COUT", v), 64'(last_cout), 64'(tv[v].c));
         chk($sformatf("v%0d_GNT", v),  64'(last_gnt),  64'(tv[v].idx));
         chk($sformatf("v%0d_ERR", v),  64'(last_err),  64'(0));
         chk($sformatf("v%0d_S_A", v),  64'(S_A),       64'(tv[v].a));
         chk($sformatf("v%0d_ack0", v), 64'(M_ack),     64'(0));
      end

      // Contention: two requests in the same cycle with ptr at 0
      o0 = ord_n;
      issue(0, 25'h0000010, 25'h0000020);
      issue(1, 25'h0000100, 25'h0000200);
      wait_served(0, quota[0], 60);
      wait_served(1, quota[1], 60);
      @(negedge CLK);
      chk("cont_first",  64'(ord[o0]),     64'(0));
      chk("cont_second", 64'(ord[o0 + 1]), 64'(1));
      chk("cont_Z",      64'(last_z),      64'(25'h0000300));
      chk("cont_GNT",    64'(last_gnt),    64'(1));

      // Reset in the middle of an adder transaction
      adder_mode = 2;
      issue(1, 25'h0000005, 25'h0000007);
      wait_sreq("rstmid_sreq_up", 20);
      repeat (3) @(negedge CLK);
      RSTn = 1'b0;
      #1;
      chk("rstmid_S_req", 64'(S_req), 64'(0));
      chk("rstmid_M_ack", 64'(M_ack), 64'(0));
      chk("rstmid_S_A",   64'(S_A),   64'(0));
      @(negedge CLK);
      RSTn       = 1'b1;
      adder_mode = 0;
      wait_served(1, quota[1], 50);
      @(negedge CLK);
      chk("rstmid_Z",   64'(last_z),   64'(25'h000000C));
      chk("rstmid_GNT", 64'(last_gnt), 64'(1));

      // Stale adder ack blocks a new grant until it falls
      adder_mode = 1;
      stale_val  = 1'b1;
      repeat (2) @(negedge CLK);
      issue(0, 25'h0000003, 25'h0000004);
      seen = 1'b0;
      repeat (8) begin
         @(negedge CLK);
         if (S_req) seen = 1'b1;
      end
      chk("stale_block", 64'(seen), 64'(0));
      adder_mode = 0;
      wait_served(0, quota[0], 50);
      @(negedge CLK);
      chk("stale_Z",   64'(last_z),   64'(25'h0000007));
      chk("stale_GNT", 64'(last_gnt), 64'(0));

      // Fairness: all four requesters busy for two rounds from ptr 0
      RSTn = 1'b0;
      @(negedge CLK);
      RSTn = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         M_A[i*W +: W] = W'(i + 1);
         M_B[i*W +: W] = 25'h0000010;
      end
      o0 = ord_n;
      for (int i = 0; i < NREQ; i++) quota[i] = served[i] + 2;
      for (int i = 0; i < NREQ; i++) wait_served(i, quota[i], 200);
      @(negedge CLK);
      for (int k = 0; k < 8; k++)
         chk($sformatf("fair_%0d", k), 64'(ord[o0 + k]), 64'(k % 4));
      chk("fair_Z", 64'(last_z), 64'(25'h0000014));

`ifdef ARB_TIMEOUT_EN
      // Adder never acknowledges: abandon after 64 cycles and flag the error
      adder_mode = 2;
      issue(0, 25'h0000001, 25'h0000002);
      wait_sreq("tmo_sreq_up", 20);
      cnt = 0;
      while (S_req && cnt < 300) begin
         @(negedge CLK);
         cnt++;
      end
      chk("tmo_len", 64'(cnt), 64'(64));
      wait_served(0, quota[0], 20);
      @(negedge CLK);
      chk("tmo_ERR",  64'(last_err),  64'(1));
      chk("tmo_Z",    64'(last_z),    64'(0));
      chk("tmo_COUT", 64'(last_cout), 64'(0));
      adder_mode = 0;
      issue(2, 25'h0000002, 25'h0000002);
      wait_served(2, quota[2], 50);
      @(negedge CLK);
      chk("tmo_clr_ERR", 64'(last_err), 64'(0));
      chk("tmo_clr_Z",   64'(last_z),   64'(25'h0000004));
`else
      cnt = 0;
      chk("noerr_M_ERR", 64'(M_ERR + cnt), 64'(0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
